tlul_dmem_responder: RTL and testbench



---
 rtl/tlul_pkg.sv | 46 ++++
 rtl/tlul_lane_align.sv | 55 +++++
 rtl/tlul_dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_tlul_dmem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// Shared TL-UL types for the data-memory responder: channel A/D opcodes,
// access-size constants, responder FSM states, the latched request record
// and the lane-offset helper used by both the write and read alignment paths.
package tlul_pkg;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } d_opcode_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_e;

  // Request fields kept from the accept cycle until the response is formed.
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] size;
    logic [1:0] addr_lo;
    logic       err;
  } req_t;

  // Byte offset actually used for a given size: halves drop addr[0], words
  // (and the size-3 encoding, treated as a word) drop both low bits.
  function automatic logic [1:0] eff_offset(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: eff_offset = addr_lo;
      SZ_HALF: eff_offset = {addr_lo[1], 1'b0};
      default: eff_offset = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/tlul_lane_align.sv
// Byte-lane alignment for the data memory.
// Write side: byte-enable and lane-shifted write data from size/offset/mask.
// Read side: right-justify the stored word and zero-extend above the size.
// Ports:
//   wr_size_i, wr_addr_lo_i, wr_partial_i, wr_mask_i, wr_data_i -> wr_be_o, wr_data_o
//   rd_size_i, rd_addr_lo_i, rd_word_i                          -> rd_data_o
module tlul_lane_align
  import tlul_pkg::*;
(
  input  logic [1:0]  wr_size_i,
  input  logic [1:0]  wr_addr_lo_i,
  input  logic        wr_partial_i,
  input  logic [3:0]  wr_mask_i,
  input  logic [31:0] wr_data_i,
  output logic [3:0]  wr_be_o,
  output logic [31:0] wr_data_o,
  input  logic [1:0]  rd_size_i,
  input  logic [1:0]  rd_addr_lo_i,
  input  logic [31:0] rd_word_i,
  output logic [31:0] rd_data_o
);

  logic [1:0]  wr_off;
  logic [1:0]  rd_off;
  logic [31:0] rd_shifted;

  // Write lanes: partial puts carry their own mask and unshifted lanes.
  always_comb begin
    wr_off    = eff_offset(wr_size_i, wr_addr_lo_i);
    wr_be_o   = 4'hF;
    wr_data_o = wr_data_i << {wr_off, 3'b000};
    if (wr_partial_i) begin
      wr_be_o   = wr_mask_i;
      wr_data_o = wr_data_i;
    end else begin
      case (wr_size_i)
        SZ_BYTE: wr_be_o = 4'b0001 << wr_off;
        SZ_HALF: wr_be_o = 4'b0011 << wr_off;
        default: wr_be_o = 4'hF;
      endcase
    end
  end

  // Read: right-justify, then zero-extend above the access size.
  always_comb begin
    rd_off     = eff_offset(rd_size_i, rd_addr_lo_i);
    rd_shifted = rd_word_i >> {rd_off, 3'b000};
    case (rd_size_i)
      SZ_BYTE: rd_data_o = {24'h0, rd_shifted[7:0]};
      SZ_HALF: rd_data_o = {16'h0, rd_shifted[15:0]};
      default: rd_data_o = rd_shifted;
    endcase
  end

endmodule

// File: rtl/tlul_dmem_responder.sv
// TL-UL device-side data-memory responder. Accepts one channel A request,
// accesses a word-organised synchronous memory in the accept cycle, forms the
// response in the following cycle and holds it on channel D until taken.
// Optional macro TLUL_DMEM_ERR_EN adds d_error_o and error detection
// (misalignment, size 3, out-of-range index, unknown opcode).
// Ports:
//   clk_i, rst_i (sync, active-high)
//   channel A: a_valid_i, a_ready_o, a_opcode_i, a_size_i, a_address_i,
//              a_mask_i, a_data_i
//   channel D: d_valid_o, d_ready_i, d_opcode_o, d_size_o, d_data_o
//              [, d_error_o]
module tlul_dmem_responder
  import tlul_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [2:0]        a_opcode_i,
  input  logic [1:0]        a_size_i,
  input  logic [ADDR_W-1:0] a_address_i,
  input  logic [3:0]        a_mask_i,
  input  logic [31:0]       a_data_i,
  output logic              d_valid_o,
  input  logic              d_ready_i,
  output logic [2:0]        d_opcode_o,
  output logic [1:0]        d_size_o,
  output logic [31:0]       d_data_o
`ifdef TLUL_DMEM_ERR_EN
  ,
  output logic              d_error_o
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  dmem_state_e state_q, state_d;
  req_t        req_q, req_d;
  logic        d_valid_q, d_valid_d;
  d_opcode_e   d_opcode_q, d_opcode_d;
  logic [1:0]  d_size_q, d_size_d;
  logic [31:0] d_data_q, d_data_d;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_word_q;

  logic [IDX_W-1:0] a_idx;
  logic        accept, is_put, is_get, err_c, mem_we, mem_re;
  logic [3:0]  wr_be;
  logic [31:0] wr_data, rd_data;

  assign a_ready_o = (state_q == IDLE);
  assign a_idx     = a_address_i[IDX_W+1:2];  // wraps modulo DEPTH
  assign accept    = a_valid_i && a_ready_o && !rst_i;
  assign is_put    = (a_opcode_i == PUT_FULL) || (a_opcode_i == PUT_PARTIAL);
  assign is_get    = (a_opcode_i == GET);

`ifdef TLUL_DMEM_ERR_EN
  logic d_error_q, d_error_d;
  logic misalign, out_of_range;

  assign misalign     = ((a_size_i == SZ_HALF) && a_address_i[0]) ||
                        ((a_size_i == SZ_WORD) && (a_address_i[1:0] != 2'b00));
  assign out_of_range = |(a_address_i >> (IDX_W + 2));
  assign err_c        = misalign || (a_size_i == 2'd3) || out_of_range ||
                        !(is_put || is_get);
  assign d_error_o    = d_error_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^(a_address_i >> (IDX_W + 2));
  assign err_c          = 1'b0;
`endif

  assign mem_we = accept && is_put && !err_c;
  assign mem_re = accept && is_get && !err_c;

  tlul_lane_align u_lane_align (
    .wr_size_i    (a_size_i),
    .wr_addr_lo_i (a_address_i[1:0]),
    .wr_partial_i (a_opcode_i == PUT_PARTIAL),
    .wr_mask_i    (a_mask_i),
    .wr_data_i    (a_data_i),
    .wr_be_o      (wr_be),
    .wr_data_o    (wr_data),
    .rd_size_i    (req_q.size),
    .rd_addr_lo_i (req_q.addr_lo),
    .rd_word_i    (rd_word_q),
    .rd_data_o    (rd_data)
  );

  // Memory array and read register; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[a_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (mem_re) rd_word_q <= mem_q[a_idx];
  end

  // Next-state and response formation.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    d_valid_d  = d_valid_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_data_d   = d_data_q;
`ifdef TLUL_DMEM_ERR_EN
    d_error_d  = d_error_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = '{opcode: a_opcode_i, size: a_size_i,
                    addr_lo: a_address_i[1:0], err: err_c};
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        d_valid_d  = 1'b1;
        d_opcode_d = (req_q.opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
        d_size_d   = req_q.size;
        d_data_d   = ((req_q.opcode == GET) && !req_q.err) ? rd_data : 32'h0;
`ifdef TLUL_DMEM_ERR_EN
        d_error_d  = req_q.err;
`endif
        state_d    = RESP;
      end
      RESP: begin
        if (d_ready_i) begin
          d_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      req_q      <= '0;
      d_valid_q  <= 1'b0;
      d_opcode_q <= ACCESS_ACK;
      d_size_q   <= 2'd0;
      d_data_q   <= 32'h0;
`ifdef TLUL_DMEM_ERR_EN
      d_error_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      d_valid_q  <= d_valid_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_data_q   <= d_data_d;
`ifdef TLUL_DMEM_ERR_EN
      d_error_q  <= d_error_d;
`endif
    end
  end

  assign d_valid_o  = d_valid_q;
  assign d_opcode_o = d_opcode_q;
  assign d_size_o   = d_size_q;
  assign d_data_o   = d_data_q;

endmodule

// File: tb/tb_tlul_dmem_responder.sv
// Self-checking bench for tlul_dmem_responder: directed vector table, hand
// sequences for backpressure and mid-transaction reset, and random traffic
// checked against a byte-addressed reference memory.
module tb_tlul_dmem_responder;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        a_valid_i;
  logic        a_ready_o;
  logic [2:0]  a_opcode_i;
  logic [1:0]  a_size_i;
  logic [31:0] a_address_i;
  logic [3:0]  a_mask_i;
  logic [31:0] a_data_i;
  logic        d_valid_o;
  logic        d_ready_i;
  logic [2:0]  d_opcode_o;
  logic [1:0]  d_size_o;
  logic [31:0] d_data_o;
`ifdef TLUL_DMEM_ERR_EN
  logic        d_error_o;
`endif

  tlul_dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .a_valid_i   (a_valid_i),
    .a_ready_o   (a_ready_o),
    .a_opcode_i  (a_opcode_i),
    .a_size_i    (a_size_i),
    .a_address_i (a_address_i),
    .a_mask_i    (a_mask_i),
    .a_data_i    (a_data_i),
    .d_valid_o   (d_valid_o),
    .d_ready_i   (d_ready_i),
    .d_opcode_o  (d_opcode_o),
    .d_size_o    (d_size_o),
    .d_data_o    (d_data_o)
`ifdef TLUL_DMEM_ERR_EN
    ,
    .d_error_o   (d_error_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] ref_mem [DEPTH*4];

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    int          bp;
    logic [2:0]  exp_op;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: byte-addressed memory, accesses expressed as byte ranges.
  task automatic model(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data,
                       output logic [2:0] e_op, output logic [31:0] e_data, output logic e_err);
    int unsigned n, ba, base;
    logic known;
    n     = (size == 2'd3) ? 4 : (1 << size);
    ba    = addr % (DEPTH * 4);
    base  = ba - (ba % n);
    known = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
    e_op   = (op == 3'd4) ? 3'd1 : 3'd0;
    e_data = 32'h0;
    e_err  = 1'b0;
`ifdef TLUL_DMEM_ERR_EN
    e_err = !known || (size == 2'd3) || ((addr % n) != 0) || (addr >= DEPTH * 4);
`else
    if (!known) e_err = 1'b0;
`endif
    if (!e_err) begin
      if (op == 3'd0) begin
        for (int k = 0; k < int'(n); k++) ref_mem[base + k] = data[8*k +: 8];
      end else if (op == 3'd1) begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) ref_mem[(ba & ~32'd3) + b] = data[8*b +: 8];
      end else if (op == 3'd4) begin
        for (int k = 0; k < int'(n); k++) e_data = e_data | (32'(ref_mem[base + k]) << (8 * k));
      end
    end
  endtask

  // One full request/response with latency, stall and handshake checks.
  task automatic txn(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                     input logic [3:0] mask, input logic [31:0] data, input int bp,
                     input logic [2:0] e_op, input logic [31:0] e_data, input logic e_err,
                     input string tag);
    @(negedge clk_i);
    a_valid_i = 1'b1; a_opcode_i = op; a_size_i = size;
    a_address_i = addr; a_mask_i = mask; a_data_i = data;
    check($sformatf("%s a_ready", tag), 32'(a_ready_o), 32'd1);
    @(negedge clk_i);
    a_valid_i = 1'b0;
    check($sformatf("%s access rdy/vld", tag), 32'({a_ready_o, d_valid_o}), 32'd0);
    @(negedge clk_i);
    check($sformatf("%s d_valid at +2", tag), 32'({a_ready_o, d_valid_o}), 32'd1);
    check($sformatf("%s d_opcode", tag), 32'(d_opcode_o), 32'(e_op));
    check($sformatf("%s d_size", tag), 32'(d_size_o), 32'(size));
    check($sformatf("%s d_data", tag), d_data_o, e_data);
`ifdef TLUL_DMEM_ERR_EN
    check($sformatf("%s d_error", tag), 32'(d_error_o), 32'(e_err));
`else
    if (e_err) check($sformatf("%s unexpected error", tag), 32'(e_err), 32'd0);
`endif
    for (int i = 0; i < bp; i++) begin
      @(negedge clk_i);
      check($sformatf("%s stall rdy/vld", tag), 32'({a_ready_o, d_valid_o}), 32'd1);
      check($sformatf("%s stall data", tag), d_data_o, e_data);
    end
    d_ready_i = 1'b1;
    @(negedge clk_i);
    d_ready_i = 1'b0;
    check($sformatf("%s post handshake", tag), 32'({a_ready_o, d_valid_o}), 32'd2);
  endtask

  initial begin
    logic [2:0]  e_op, r_op;
    logic [31:0] e_data, r_addr;
    logic [1:0]  r_size;
    logic        e_err;
    int          r;

    rst_i = 1'b1; a_valid_i = 1'b0; a_opcode_i = 3'd0; a_size_i = 2'd0;
    a_address_i = 32'h0; a_mask_i = 4'h0; a_data_i = 32'h0; d_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("reset a_ready", 32'(a_ready_o), 32'd1);
    check("reset d_valid", 32'(d_valid_o), 32'd0);
    check("reset d_opcode", 32'(d_opcode_o), 32'd0);
    check("reset d_size", 32'(d_size_o), 32'd0);
    check("reset d_data", d_data_o, 32'h0);
`ifdef TLUL_DMEM_ERR_EN
    check("reset d_error", 32'(d_error_o), 32'd0);
`endif

    // op, size, addr, mask, data, backpressure, exp_op, exp_data, exp_err
    vecs.push_back('{3'd0, 2'd2, 32'h10, 4'h0, 32'hDEADBEEF, 0, 3'd0, 32'h0,        1'b0});
    vecs.push_back('{3'd4, 2'd2, 32'h10, 4'h0, 32'h0,        5, 3'd1, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{3'd0, 2'd2, 32'h10, 4'h0, 32'h11223344, 0, 3'd0, 32'h0,        1'b0});
    vecs.push_back('{3'd0, 2'd0, 32'h13, 4'h0, 32'h000000A5, 0, 3'd0, 32'h0,        1'b0});
    vecs.push_back('{3'd4, 2'd2, 32'h10, 4'h0, 32'h0,        0, 3'd1, 32'hA5223344, 1'b0});
    vecs.push_back('{3'd4, 2'd0, 32'h13, 4'h0, 32'h0,        0, 3'd1, 32'h000000A5, 1'b0});
    vecs.push_back('{3'd0, 2'd2, 32'h20, 4'h0, 32'hCAFEBABE, 0, 3'd0, 32'h0,        1'b0});
    vecs.push_back('{3'd4, 2'd1, 32'h22, 4'h0, 32'h0,        0, 3'd1, 32'h0000CAFE, 1'b0});
    vecs.push_back('{3'd1, 2'd2, 32'h20, 4'h5, 32'h11223344, 0, 3'd0, 32'h0,        1'b0});
    vecs.push_back('{3'd4, 2'd2, 32'h20, 4'h0, 32'h0,        0, 3'd1, 32'hCA22BA44, 1'b0});
    vecs.push_back('{3'd0, 2'd1, 32'h22, 4'h0, 32'h00005678, 0, 3'd0, 32'h0,        1'b0});
    vecs.push_back('{3'd4, 2'd1, 32'h20, 4'h0, 32'h0,        0, 3'd1, 32'h0000BA44, 1'b0});
    vecs.push_back('{3'd4, 2'd0, 32'h21, 4'h0, 32'h0,        0, 3'd1, 32'h000000BA, 1'b0});
`ifdef TLUL_DMEM_ERR_EN
    vecs.push_back('{3'd0, 2'd2, 32'h00, 4'h0, 32'h0BADF00D, 0, 3'd0, 32'h0,        1'b0});
    vecs.push_back('{3'd0, 2'd2, 32'h02, 4'h0, 32'hFFFFFFFF, 0, 3'd0, 32'h0,        1'b1});
    vecs.push_back('{3'd4, 2'd2, 32'h00, 4'h0, 32'h0,        0, 3'd1, 32'h0BADF00D, 1'b0});
    vecs.push_back('{3'd4, 2'd1, 32'h21, 4'h0, 32'h0,        0, 3'd1, 32'h0,        1'b1});
    vecs.push_back('{3'd4, 2'd2, 32'h1000, 4'h0, 32'h0,      0, 3'd1, 32'h0,        1'b1});
    vecs.push_back('{3'd2, 2'd2, 32'h00, 4'h0, 32'h0,        0, 3'd0, 32'h0,        1'b1});
`else
    vecs.push_back('{3'd0, 2'd1, 32'h21, 4'h0, 32'h00001234, 0, 3'd0, 32'h0,        1'b0});
    vecs.push_back('{3'd4, 2'd3, 32'h20, 4'h0, 32'h0,        0, 3'd1, 32'h56781234, 1'b0});
    vecs.push_back('{3'd2, 2'd2, 32'h20, 4'h0, 32'hFFFFFFFF, 0, 3'd0, 32'h0,        1'b0});
    vecs.push_back('{3'd4, 2'd2, 32'h1020, 4'h0, 32'h0,      0, 3'd1, 32'h56781234, 1'b0});
`endif
    foreach (vecs[i])
      txn(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].bp,
          vecs[i].exp_op, vecs[i].exp_data, vecs[i].exp_err, $sformatf("vec%0d", i));

    // Reset while in ACCESS aborts the Get; the earlier Put stays committed.
    txn(3'd0, 2'd2, 32'h30, 4'h0, 32'h77777777, 0, 3'd0, 32'h0, 1'b0, "rst put");
    @(negedge clk_i);
    a_valid_i = 1'b1; a_opcode_i = 3'd4; a_size_i = 2'd2; a_address_i = 32'h30;
    @(negedge clk_i);
    a_valid_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst abort rdy/vld", 32'({a_ready_o, d_valid_o}), 32'd2);
    check("rst abort d_data", d_data_o, 32'h0);
    @(negedge clk_i);
    check("rst abort stays idle", 32'({a_ready_o, d_valid_o}), 32'd2);
    txn(3'd4, 2'd2, 32'h30, 4'h0, 32'h0, 0, 3'd1, 32'h77777777, 1'b0, "rst readback");

    // Preload the random window with known words.
    for (int w = 0; w < 16; w++) begin
      model(3'd0, 2'd2, 32'(w * 4), 4'h0, $urandom, e_op, e_data, e_err);
      txn(3'd0, 2'd2, 32'(w * 4), 4'h0,
          {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]},
          0, e_op, e_data, e_err, $sformatf("preload%0d", w));
    end

    for (int t = 0; t < 250; t++) begin
      logic [3:0]  r_mask;
      logic [31:0] r_data;
      r = $urandom_range(0, 9);
      r_op = (r < 4) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd4 : (r[0] ? 3'd2 : 3'd7);
      r_size = 2'($urandom_range(0, 3));
      r_addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) r_addr = r_addr + 32'($urandom_range(1, 3)) * DEPTH * 4;
      r_mask = 4'($urandom);
      r_data = $urandom;
      model(r_op, r_size, r_addr, r_mask, r_data, e_op, e_data, e_err);
      txn(r_op, r_size, r_addr, r_mask, r_data, $urandom_range(0, 2), e_op, e_data, e_err,
          $sformatf("rnd%0d op%0d sz%0d a%08h", t, r_op, r_size, r_addr));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
